// File: rtl/nf10_1g_rx_frame_filter.sv
// rtl/nf10_1g_rx_frame_filter.sv - store-and-forward byte-wide rx frame filter
module nf10_1g_rx_frame_filter #(
  parameter int ADDR_WIDTH    = 12,
  parameter int MIN_FRAME_LEN = 60,
  parameter int MAX_FRAME_LEN = 1518
) (
  input  logic        axi_aclk,
  input  logic        axi_resetn,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tstrb,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  input  logic        s_axis_err,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tstrb,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic [31:0] stat_good_frames,
  output logic [31:0] stat_bad_frames,
  output logic [31:0] stat_overflow_frames
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] PTR_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [10:0] LEN_SAT = 11'h7FF;
  localparam logic [10:0] MIN_LEN = 11'(MIN_FRAME_LEN);
  localparam logic [10:0] MAX_LEN = 11'(MAX_FRAME_LEN);

  typedef enum logic [1:0] {IDLE = 2'd0, FRAME = 2'd1, DROP = 2'd2} state_t;
  state_t state, state_nxt;

  logic [8:0] mem [DEPTH];
  logic [ADDR_WIDTH:0] wr_ptr, wr_commit, rd_ptr;
  logic [10:0] len, len_nxt;
  logic drop_ovf, ready_q;
  logic beat, full, oversize;
  logic do_write, do_commit, do_rewind, do_len, set_drop, set_drop_ovf;
  logic inc_good, inc_bad, inc_ovf;
  logic rd_en, rd_vld, pop;
  logic [8:0] ram_q, pipe0, pipe1;
  logic [1:0] pipe_cnt;
  logic unused_tstrb;

  assign unused_tstrb  = s_axis_tstrb;
  assign s_axis_tready = ready_q;
  assign beat     = s_axis_tvalid & ready_q;
  assign full     = (wr_ptr - rd_ptr) == FULL_CNT;
  assign len_nxt  = (state == IDLE) ? 11'd1 : ((len == LEN_SAT) ? LEN_SAT : len + 11'd1);
  assign oversize = len_nxt > MAX_LEN;

  // Input side accepts every beat once out of reset
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) ready_q <= 1'b0;
    else             ready_q <= 1'b1;
  end

  // Input FSM state register
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) state <= IDLE;
    else             state <= state_nxt;
  end

  // Input FSM next state: any tlast ends the frame, full/oversize mid-frame drops the rest
  always_comb begin
    state_nxt = state;
    if (beat) begin
      case (state)
        IDLE, FRAME: begin
          if (s_axis_tlast)          state_nxt = IDLE;
          else if (full || oversize) state_nxt = DROP;
          else                       state_nxt = FRAME;
        end
        DROP:    if (s_axis_tlast) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Input FSM actions: write, commit or rewind, and which counter a frame lands in
  always_comb begin
    do_write     = 1'b0;
    do_commit    = 1'b0;
    do_rewind    = 1'b0;
    do_len       = 1'b0;
    set_drop     = 1'b0;
    set_drop_ovf = 1'b0;
    inc_good     = 1'b0;
    inc_bad      = 1'b0;
    inc_ovf      = 1'b0;
    if (beat) begin
      case (state)
        IDLE, FRAME: begin
          if (full) begin
            do_rewind = 1'b1;
            if (s_axis_tlast) inc_ovf = 1'b1;
            else begin
              set_drop     = 1'b1;
              set_drop_ovf = 1'b1;
            end
          end else if (oversize) begin
            do_rewind = 1'b1;
            if (s_axis_tlast) inc_bad = 1'b1;
            else              set_drop = 1'b1;
          end else begin
            do_write = 1'b1;
            if (!s_axis_tlast) do_len = 1'b1;
            else if (s_axis_err || (len_nxt < MIN_LEN)) begin
              do_rewind = 1'b1;
              inc_bad   = 1'b1;
            end else begin
              do_commit = 1'b1;
              inc_good  = 1'b1;
            end
          end
        end
        DROP: begin
          if (s_axis_tlast) begin
            inc_ovf = drop_ovf;
            inc_bad = ~drop_ovf;
          end
        end
        default: ;
      endcase
    end
  end

  // Write pointers: speculative wr_ptr, wr_commit only moves on a released frame
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      wr_ptr    <= '0;
      wr_commit <= '0;
      len       <= '0;
      drop_ovf  <= 1'b0;
    end else begin
      if (do_commit) begin
        wr_ptr    <= wr_ptr + PTR_ONE;
        wr_commit <= wr_ptr + PTR_ONE;
      end else if (do_rewind) begin
        wr_ptr <= wr_commit;
      end else if (do_write) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_len)   len      <= len_nxt;
      if (set_drop) drop_ovf <= set_drop_ovf;
    end
  end

  // Frame counters, exactly one bump per frame, saturating
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      stat_good_frames     <= '0;
      stat_bad_frames      <= '0;
      stat_overflow_frames <= '0;
    end else begin
      if (inc_good && (stat_good_frames != 32'hFFFF_FFFF))
        stat_good_frames <= stat_good_frames + 32'd1;
      if (inc_bad && (stat_bad_frames != 32'hFFFF_FFFF))
        stat_bad_frames <= stat_bad_frames + 32'd1;
      if (inc_ovf && (stat_overflow_frames != 32'hFFFF_FFFF))
        stat_overflow_frames <= stat_overflow_frames + 32'd1;
    end
  end

  // Frame buffer storage and synchronous read port
  always_ff @(posedge axi_aclk) begin
    if (do_write) mem[wr_ptr[ADDR_WIDTH-1:0]] <= {s_axis_tlast, s_axis_tdata};
    if (rd_en)    ram_q <= mem[rd_ptr[ADDR_WIDTH-1:0]];
  end

  // Issue a read only if the pipeline plus the in-flight read still fit in two slots
  assign pop   = (pipe_cnt != 2'd0) & m_axis_tready;
  assign rd_en = (rd_ptr != wr_commit) &&
                 (({1'b0, pipe_cnt} + {2'b00, rd_vld}) <= ({2'b00, pop} + 3'd1));

  // Read pointer, in-flight flag and 2-entry output pipeline (entry 0 drives the output)
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      rd_ptr   <= '0;
      rd_vld   <= 1'b0;
      pipe_cnt <= 2'd0;
      pipe0    <= '0;
      pipe1    <= '0;
    end else begin
      rd_vld <= rd_en;
      if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
      case ({rd_vld, pop})
        2'b10: begin
          if (pipe_cnt == 2'd0) pipe0 <= ram_q;
          else                  pipe1 <= ram_q;
          pipe_cnt <= pipe_cnt + 2'd1;
        end
        2'b01: begin
          pipe0    <= pipe1;
          pipe_cnt <= pipe_cnt - 2'd1;
        end
        2'b11: begin
          if (pipe_cnt == 2'd2) begin
            pipe0 <= pipe1;
            pipe1 <= ram_q;
          end else begin
            pipe0 <= ram_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign m_axis_tvalid = (pipe_cnt != 2'd0);
  assign m_axis_tstrb  = m_axis_tvalid;
  assign m_axis_tdata  = pipe0[7:0];
  assign m_axis_tlast  = pipe0[8] & m_axis_tvalid;
endmodule

// File: tb/tb_nf10_1g_rx_frame_filter.sv
// tb/tb_nf10_1g_rx_frame_filter.sv - randomized self-checking bench for the rx frame filter
`timescale 1ns/1ps
module tb_nf10_1g_rx_frame_filter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic [7:0]  s_tdata;
  logic        s_tstrb, s_tlast, s_err, s_tvalid, s8_tvalid;
  logic        s_tready, s8_tready;
  logic [7:0]  m_tdata, m8_tdata;
  logic        m_tstrb, m8_tstrb, m_tvalid, m8_tvalid, m_tlast, m8_tlast;
  logic        m_tready, m8_tready;
  logic [31:0] good, bad, ovf, good8, bad8, ovf8;

  nf10_1g_rx_frame_filter dut (
    .axi_aclk(clk), .axi_resetn(resetn),
    .s_axis_tdata(s_tdata), .s_axis_tstrb(s_tstrb), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready), .s_axis_tlast(s_tlast), .s_axis_err(s_err),
    .m_axis_tdata(m_tdata), .m_axis_tstrb(m_tstrb), .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
    .stat_good_frames(good), .stat_bad_frames(bad), .stat_overflow_frames(ovf)
  );

  nf10_1g_rx_frame_filter #(.ADDR_WIDTH(8), .MIN_FRAME_LEN(60), .MAX_FRAME_LEN(256)) dut8 (
    .axi_aclk(clk), .axi_resetn(resetn),
    .s_axis_tdata(s_tdata), .s_axis_tstrb(s_tstrb), .s_axis_tvalid(s8_tvalid),
    .s_axis_tready(s8_tready), .s_axis_tlast(s_tlast), .s_axis_err(s_err),
    .m_axis_tdata(m8_tdata), .m_axis_tstrb(m8_tstrb), .m_axis_tvalid(m8_tvalid),
    .m_axis_tready(m8_tready), .m_axis_tlast(m8_tlast),
    .stat_good_frames(good8), .stat_bad_frames(bad8), .stat_overflow_frames(ovf8)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int mgood = 0, mbad = 0;
  logic [8:0] exp0[$], exp8[$], last_frame[$];
  logic       prev_stall [2];
  logic [8:0] prev_beat [2];
  int   rdy_mode = 0;
  logic rdy_fix  = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic mon_one(input int k, input logic v, input logic r, input logic l,
                         input logic [7:0] d, input logic strb);
    logic [8:0] e;
    int sz;
    check("tstrb_eq_tvalid", 32'(strb), 32'(v));
    if (prev_stall[k]) check("hold_during_stall", 32'({v, l, d}), 32'({1'b1, prev_beat[k]}));
    if (v && r) begin
      sz = (k == 0) ? exp0.size() : exp8.size();
      if (sz == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL out_unexpected dut%0d: got byte %0h, required none", k, {l, d});
      end else begin
        if (k == 0) e = exp0.pop_front();
        else        e = exp8.pop_front();
        check("out_beat", 32'({l, d}), 32'(e));
      end
    end
    prev_stall[k] = v & ~r;
    prev_beat[k]  = {l, d};
  endtask

  // Output monitor: samples both DUTs on the falling edge
  always @(negedge clk) begin
    if (!resetn) begin
      prev_stall[0] = 1'b0;
      prev_stall[1] = 1'b0;
    end else begin
      mon_one(0, m_tvalid,  m_tready,  m_tlast,  m_tdata,  m_tstrb);
      mon_one(1, m8_tvalid, m8_tready, m8_tlast, m8_tdata, m8_tstrb);
    end
  end

  // Downstream ready for the main DUT: fixed or 50% random
  initial begin
    m_tready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      m_tready = (rdy_mode == 1) ? 1'($urandom % 2) : rdy_fix;
    end
  end

  task automatic wait_space(input int len);
    int t = 0;
    while ((exp0.size() + len > 4000) && (t < 20000)) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (exp0.size() + len > 4000) check("space_timeout", 32'(exp0.size()), 32'(0));
  endtask

  task automatic send_frame(input int len, input bit err, input bit sel, input bit gaps);
    logic [8:0] b;
    if (!sel) wait_space(len);
    last_frame.delete();
    check("s_tready_high", 32'(sel ? s8_tready : s_tready), 32'(1));
    for (int i = 0; i < len; i++) begin
      if (gaps && (($urandom % 8) == 0)) begin
        s_tvalid  = 1'b0;
        s8_tvalid = 1'b0;
        @(posedge clk);
        #1;
      end
      b = {1'(i == len - 1), 8'($urandom)};
      s_tdata = b[7:0];
      s_tlast = b[8];
      s_err   = b[8] ? err : 1'($urandom % 2);
      if (sel) s8_tvalid = 1'b1;
      else     s_tvalid  = 1'b1;
      last_frame.push_back(b);
      @(posedge clk);
      #1;
    end
    s_tvalid  = 1'b0;
    s8_tvalid = 1'b0;
    s_tlast   = 1'b0;
    s_err     = 1'b0;
    if (!sel) begin
      if (err || (len < 60) || (len > 1518)) mbad++;
      else begin
        mgood++;
        foreach (last_frame[j]) exp0.push_back(last_frame[j]);
      end
    end
  endtask

  task automatic drain(input bit sel);
    int t = 0;
    while ((sel ? exp8.size() : exp0.size()) != 0 && (t < 40000)) begin
      @(posedge clk);
      #1;
      t++;
    end
    if ((sel ? exp8.size() : exp0.size()) != 0) begin
      check("drain_timeout", 32'(sel ? exp8.size() : exp0.size()), 32'(0));
      exp0.delete();
      exp8.delete();
    end
    repeat (4) @(posedge clk);
    #1;
    check("idle_after_drain", 32'(sel ? m8_tvalid : m_tvalid), 32'(0));
  endtask

  task automatic check_stats(input int g, input int b, input int o);
    check("good_lit", good, 32'(g));
    check("bad_lit",  bad,  32'(b));
    check("ovf_lit",  ovf,  32'(o));
    check("good_model", good, 32'(mgood));
    check("bad_model",  bad,  32'(mbad));
  endtask

  initial begin
    logic [8:0] first8;
    resetn = 1'b0; s_tdata = '0; s_tstrb = 1'b1; s_tlast = 1'b0; s_err = 1'b0;
    s_tvalid = 1'b0; s8_tvalid = 1'b0; m8_tready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", 32'(m_tvalid), 32'(0));
    check("rst_tdata",  32'(m_tdata),  32'(0));
    check("rst_tready", 32'(s_tready), 32'(0));
    check("rst_good",   good, 32'(0));
    resetn = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 1: single good frame, latency and contents
    send_frame(64, 0, 0, 0);
    @(negedge clk); check("t1_lat_0", 32'(m_tvalid), 32'(0));
    @(negedge clk); check("t1_lat_1", 32'(m_tvalid), 32'(0));
    @(negedge clk); check("t1_lat_2", 32'(m_tvalid), 32'(1));
    drain(0);
    check_stats(1, 0, 0);

    // 2: errored frame dropped, following good frame passes
    send_frame(64, 1, 0, 1);
    send_frame(64, 0, 0, 1);
    drain(0);
    check_stats(2, 1, 0);

    // 3: runt and oversize dropped, max-length passes
    send_frame(59, 0, 0, 1);
    send_frame(1519, 0, 0, 0);
    send_frame(1518, 0, 0, 0);
    drain(0);
    check_stats(3, 3, 0);

    // 4: small buffer overflow with downstream stalled
    m8_tready = 1'b0;
    send_frame(200, 0, 1, 1);
    foreach (last_frame[j]) exp8.push_back(last_frame[j]);
    first8 = last_frame[0];
    send_frame(100, 0, 1, 1);
    repeat (5) @(posedge clk);
    #1;
    check("t4_ovf8",  ovf8,  32'(1));
    check("t4_good8", good8, 32'(1));
    check("t4_bad8",  bad8,  32'(0));
    check("t4_head",  32'({m8_tvalid, m8_tlast, m8_tdata}), 32'({1'b1, first8}));
    m8_tready = 1'b1;
    drain(1);
    send_frame(100, 0, 1, 0);
    foreach (last_frame[j]) exp8.push_back(last_frame[j]);
    drain(1);
    check("t4_good8_end", good8, 32'(2));
    check("t4_ovf8_end",  ovf8,  32'(1));

    // 5: random backpressure, back-to-back good frames
    rdy_mode = 1;
    for (int f = 0; f < 20; f++) send_frame(int'($urandom_range(1518, 60)), 0, 0, (f % 3) == 0);
    drain(0);
    rdy_mode = 0;
    check_stats(23, 3, 0);

    // 6: reset while output is stalled and input is mid-frame
    rdy_fix = 1'b0;
    send_frame(300, 0, 0, 0);
    for (int i = 0; i < 30; i++) begin
      s_tdata = 8'($urandom); s_tlast = 1'b0; s_tvalid = 1'b1;
      @(posedge clk);
      #1;
    end
    check("t6_valid_before", 32'(m_tvalid), 32'(1));
    resetn = 1'b0;
    #1;
    check("t6_rst_tvalid", 32'(m_tvalid), 32'(0));
    check("t6_rst_tdata",  32'(m_tdata),  32'(0));
    check("t6_rst_tlast",  32'(m_tlast),  32'(0));
    check("t6_rst_tstrb",  32'(m_tstrb),  32'(0));
    check("t6_rst_tready", 32'(s_tready), 32'(0));
    check("t6_rst_good",   good, 32'(0));
    exp0.delete();
    mgood = 0;
    mbad  = 0;
    s_tvalid = 1'b0;
    @(posedge clk);
    #1;
    resetn  = 1'b1;
    rdy_fix = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    send_frame(100, 0, 0, 1);
    drain(0);
    check_stats(1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
